// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: opcodes, states,
// datapath mux selects and the ALU operand choice per opcode.
package mc_pkg;

   localparam logic [6:0] ArithmeticR   = 7'b0110011;
   localparam logic [6:0] ArithmeticI   = 7'b0010011;
   localparam logic [6:0] MemoryLoad    = 7'b0000011;
   localparam logic [6:0] MemoryStore   = 7'b0100011;
   localparam logic [6:0] Conditionjump = 7'b1100011;
   localparam logic [6:0] JumpandlinkR  = 7'b1100111;
   localparam logic [6:0] JumpandlinkI  = 7'b1101111;
   localparam logic [6:0] Adduppertopc  = 7'b0010111;
   localparam logic [6:0] Loadupperimm  = 7'b0110111;
   localparam logic [6:0] ControlStatus = 7'b1110011;

   typedef enum logic [2:0] {
      st_fetch, st_decode, st_exec, st_mem, st_wb, st_halt
   } state_t;

   localparam logic [1:0] pc_plus4 = 2'd0;
   localparam logic [1:0] pc_tgt   = 2'd1;
   localparam logic [1:0] pc_alu   = 2'd2;

   localparam logic [1:0] wb_alu  = 2'd0;
   localparam logic [1:0] wb_load = 2'd1;
   localparam logic [1:0] wb_link = 2'd2;

   localparam logic [1:0] alu_a_rs1  = 2'd0;
   localparam logic [1:0] alu_a_pc   = 2'd1;
   localparam logic [1:0] alu_a_zero = 2'd2;

   localparam logic [1:0] alu_b_rs2  = 2'd0;
   localparam logic [1:0] alu_b_imm  = 2'd1;
   localparam logic [1:0] alu_b_four = 2'd2;

   function automatic logic is_known(input logic [6:0] op);
      case (op)
         ArithmeticR, ArithmeticI, MemoryLoad, MemoryStore, Conditionjump,
         JumpandlinkR, JumpandlinkI, Adduppertopc, Loadupperimm,
         ControlStatus: return 1'b1;
         default:       return 1'b0;
      endcase
   endfunction

   // {alu_a_sel, alu_b_sel} for the execute-phase operation of each opcode;
   // held through MEM/WB so an unregistered ALU result stays valid.
   function automatic logic [3:0] exec_alu_sel(input logic [6:0] op);
      case (op)
         ArithmeticI, MemoryLoad, MemoryStore,
         JumpandlinkR:   return {alu_a_rs1, alu_b_imm};
         Loadupperimm:   return {alu_a_zero, alu_b_imm};
         Adduppertopc:   return {alu_a_pc, alu_b_imm};
         default:        return {alu_a_rs1, alu_b_rs2};
      endcase
   endfunction

endpackage

// File: rtl/mc_mem_timer.sv
// Memory wait watchdog: counts stalled request cycles and raises a sticky
// bus error when a request has waited MEM_TIMEOUT cycles.
module mc_mem_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic mem_req,
   input  logic mem_ready,
   output logic expire,
   output logic bus_err
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   logic [CW-1:0] cnt;

   assign expire = mem_req && !mem_ready && (cnt == CW'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         bus_err <= 1'b0;
      end else begin
         if (!mem_req || mem_ready || expire) cnt <= '0;
         else                                 cnt <= cnt + 1'b1;
         if (expire) bus_err <= 1'b1;
      end
   end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle RV32I control FSM driving the shared datapath.
// Optional MC_ILLEGAL_TRAP_EN: unknown opcodes raise a sticky illegal flag and halt.
module mc_control
   import mc_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr,
   input  logic             branch_cond,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic             ir_we,
   output logic             ab_we,
   output logic             tgt_we,
   output logic [1:0]       alu_a_sel,
   output logic [1:0]       alu_b_sel,
   output logic             rf_we,
   output logic [1:0]       wb_sel,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             retire,
   output logic [CNT_W-1:0] instret,
   output logic             bus_err,
`ifdef MC_ILLEGAL_TRAP_EN
   output logic             illegal,
`endif
   output logic             halted
);

   state_t      state;
   logic [6:0]  opcode;
   logic        expire;
   logic        is_jump;
   logic        instr_unused;

   assign opcode       = instr[6:0];
   assign instr_unused = ^instr[31:7];
   assign is_jump      = (opcode == JumpandlinkI) || (opcode == JumpandlinkR);
   assign halted       = (state == st_halt);

   mc_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .mem_req   (mem_req),
      .mem_ready (mem_ready),
      .expire    (expire),
      .bus_err   (bus_err)
   );

   // NOTE: every output gets a default before the case so no path leaves one
   // unassigned (which would infer a latch); blocking '=' is right in always_comb.
   always_comb begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      ab_we        = 1'b0;
      tgt_we       = 1'b0;
      alu_a_sel    = alu_a_rs1;
      alu_b_sel    = alu_b_rs2;
      rf_we        = 1'b0;
      wb_sel       = wb_alu;
      pc_we        = 1'b0;
      pc_src       = pc_plus4;
      retire       = 1'b0;
      if (!rst) begin
         case (state)
            st_fetch: begin
               mem_req = 1'b1;
               ir_we   = mem_ready;
            end
            st_decode: begin
               ab_we     = 1'b1;
               tgt_we    = 1'b1;
               alu_a_sel = alu_a_pc;
               alu_b_sel = alu_b_imm;
            end
            st_exec: begin
               {alu_a_sel, alu_b_sel} = exec_alu_sel(opcode);
               case (opcode)
                  ArithmeticR, ArithmeticI, MemoryLoad, MemoryStore,
                  Adduppertopc, Loadupperimm: ;
                  Conditionjump: begin
                     pc_we  = 1'b1;
                     pc_src = branch_cond ? pc_tgt : pc_plus4;
                     retire = 1'b1;
                  end
                  JumpandlinkI: begin
                     pc_we  = 1'b1;
                     pc_src = pc_tgt;
                  end
                  JumpandlinkR: begin
                     pc_we  = 1'b1;
                     pc_src = pc_alu;
                  end
                  default: begin
                     pc_we  = 1'b1;
                     retire = 1'b1;
                  end
               endcase
            end
            st_mem: begin
               {alu_a_sel, alu_b_sel} = exec_alu_sel(opcode);
               mem_req      = 1'b1;
               mem_addr_sel = 1'b1;
               mem_we       = (opcode == MemoryStore);
               if (mem_ready && opcode == MemoryStore) begin
                  pc_we  = 1'b1;
                  retire = 1'b1;
               end
            end
            st_wb: begin
               {alu_a_sel, alu_b_sel} = exec_alu_sel(opcode);
               rf_we  = 1'b1;
               retire = 1'b1;
               pc_we  = !is_jump;
               if (opcode == MemoryLoad) wb_sel = wb_load;
               else if (is_jump)         wb_sel = wb_link;
            end
            default: ;
         endcase
      end
   end

   // NOTE: state and counters use non-blocking '<=' so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= st_fetch;
         instret <= '0;
`ifdef MC_ILLEGAL_TRAP_EN
         illegal <= 1'b0;
`endif
      end else begin
         if (retire) instret <= instret + 1'b1;
         case (state)
            st_fetch:
               if (expire)         state <= st_halt;
               else if (mem_ready) state <= st_decode;
            st_decode:
`ifdef MC_ILLEGAL_TRAP_EN
               if (!is_known(opcode)) begin
                  illegal <= 1'b1;
                  state   <= st_halt;
               end else
`endif
               state <= st_exec;
            st_exec:
               case (opcode)
                  ArithmeticR, ArithmeticI, JumpandlinkI, JumpandlinkR,
                  Adduppertopc, Loadupperimm: state <= st_wb;
                  MemoryLoad, MemoryStore:    state <= st_mem;
                  default:                    state <= st_fetch;
               endcase
            st_mem:
               if (expire)         state <= st_halt;
               else if (mem_ready) state <= (opcode == MemoryLoad) ? st_wb : st_fetch;
            st_wb:   state <= st_fetch;
            st_halt: state <= st_halt;
            default: state <= st_fetch;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: strobe events are predicted per scenario
// and matched by an independent monitor; status outputs are checked inline.
module tb_mc_control;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = 32'h0;
   logic        branch_cond = 1'b0;
   logic        mem_ready = 1'b0;
   logic        mem_req, mem_we, mem_addr_sel, ir_we, ab_we, tgt_we;
   logic [1:0]  alu_a_sel, alu_b_sel, wb_sel, pc_src;
   logic        rf_we, pc_we, retire, bus_err, halted;
   logic [31:0] instret;
`ifdef MC_ILLEGAL_TRAP_EN
   logic        illegal;
`endif

   mc_control #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .instr        (instr),
      .branch_cond  (branch_cond),
      .mem_ready    (mem_ready),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr_sel (mem_addr_sel),
      .ir_we        (ir_we),
      .ab_we        (ab_we),
      .tgt_we       (tgt_we),
      .alu_a_sel    (alu_a_sel),
      .alu_b_sel    (alu_b_sel),
      .rf_we        (rf_we),
      .wb_sel       (wb_sel),
      .pc_we        (pc_we),
      .pc_src       (pc_src),
      .retire       (retire),
      .instret      (instret),
      .bus_err      (bus_err),
`ifdef MC_ILLEGAL_TRAP_EN
      .illegal      (illegal),
`endif
      .halted       (halted)
   );

   always #5 clk = ~clk;

   int cyc  = 0;
   int base = 0;
   int total = 0;
   int bad   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         at;
      logic [6:0] v;   // {rf_we, wb_sel, pc_we, pc_src, retire}
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_ev(input int at, input logic rf, input logic [1:0] wb,
                            input logic pw, input logic [1:0] ps, input logic r);
      exp_t e;
      e.at = at;
      e.v  = {rf, wb, pw, ps, r};
      sb.push_back(e);
   endtask

   // Cycle n of a scenario: cycle 1 is the first cycle after rst deasserts.
   task automatic goto(input int n);
      while (cyc - base + 1 < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset;
      @(posedge clk);
      #1;
      rst = 1'b1;
      mem_ready = 1'b0;
      branch_cond = 1'b0;
      #1;
      check("rst_mem_req_gated", mem_req, 0);
      @(posedge clk);
      #1;
      rst  = 1'b0;
      base = cyc;
   endtask

   always @(negedge clk) begin
      exp_t e;
      #2;
      if (retire === 1'b1 || pc_we === 1'b1 || rf_we === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe: got %h at cycle %0d expected none",
                     {rf_we, wb_sel, pc_we, pc_src, retire}, cyc - base + 1);
         end else begin
            e = sb.pop_front();
            check("event_cycle", cyc - base + 1, e.at);
            check("event_strobes", {rf_we, wb_sel, pc_we, pc_src, retire}, e.v);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench did not complete");
   end

   initial begin
      // addi x1,x0,5: F D E W, write-back in cycle 4
      do_reset;
      instr = 32'h0050_0093;
      mem_ready = 1'b1;
      #1;
      check("s1_reset_instret", instret, 0);
      check("s1_reset_bus_err", bus_err, 0);
      check("s1_reset_halted", halted, 0);
      check("s1_first_mem_req", mem_req, 1);
      check("s1_ir_we", ir_we, 1);
      expect_ev(4, 1'b1, 2'd0, 1'b1, 2'd0, 1'b1);
      goto(5);
      mem_ready = 1'b0;
      #1;
      check("s1_instret", instret, 1);
      check("s1_back_to_fetch", mem_req, 1);

      // sw x2,0(x1): MEM stalls 3 cycles, accepted in cycle 7
      do_reset;
      instr = 32'h0020_A023;
      mem_ready = 1'b1;
      expect_ev(7, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1);
      goto(2);
      mem_ready = 1'b0;
      for (int k = 3; k <= 8; k++) begin
         goto(k);
         if (k == 7) mem_ready = 1'b1;
         if (k == 8) mem_ready = 1'b0;
         #1;
         check($sformatf("s2_mem_we_c%0d", k), mem_we, (k >= 4 && k <= 7));
      end
      check("s2_instret", instret, 1);

      // beq taken then not taken, 3 cycles each
      do_reset;
      instr = 32'h0000_0463;
      mem_ready = 1'b1;
      branch_cond = 1'b1;
      expect_ev(3, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1);
      expect_ev(6, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1);
      goto(4);
      branch_cond = 1'b0;
      goto(7);
      mem_ready = 1'b0;
      #1;
      check("s3_instret", instret, 2);

      // fetch never answered: 16 cycles of mem_req then HALT
      do_reset;
      instr = 32'h0050_0093;
      goto(16);
      #1;
      check("s4_c16_mem_req", mem_req, 1);
      check("s4_c16_halted", halted, 0);
      check("s4_c16_bus_err", bus_err, 0);
      goto(17);
      #1;
      check("s4_c17_halted", halted, 1);
      check("s4_c17_bus_err", bus_err, 1);
      check("s4_c17_mem_req", mem_req, 0);
      goto(20);
      #1;
      check("s4_halt_sticky", halted, 1);
      do_reset;
      #1;
      check("s4_rst_bus_err", bus_err, 0);
      check("s4_rst_halted", halted, 0);
      check("s4_rst_fetch", mem_req, 1);

      // jal: PC from target in EXEC, link write without pc_we in WB
      do_reset;
      instr = 32'h0000_006F;
      mem_ready = 1'b1;
      expect_ev(3, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0);
      expect_ev(4, 1'b1, 2'd2, 1'b0, 2'd0, 1'b1);
      goto(5);
      mem_ready = 1'b0;
      #1;
      check("s5_instret", instret, 1);

      // lw completing: F D E M W
      do_reset;
      instr = 32'h0000_A083;
      mem_ready = 1'b1;
      expect_ev(5, 1'b1, 2'd1, 1'b1, 2'd0, 1'b1);
      goto(4);
      #1;
      check("s6_mem_addr_sel", mem_addr_sel, 1);
      check("s6_mem_we", mem_we, 0);
      goto(6);
      mem_ready = 1'b0;
      #1;
      check("s6_instret", instret, 1);

      // lw interrupted by rst in MEM
      do_reset;
      instr = 32'h0000_A083;
      mem_ready = 1'b1;
      goto(2);
      mem_ready = 1'b0;
      goto(4);
      #1;
      check("s7_in_mem", {mem_req, mem_addr_sel}, 2'b11);
      rst = 1'b1;
      mem_ready = 1'b1;
      #1;
      check("s7_rst_pc_we", pc_we, 0);
      check("s7_rst_rf_we", rf_we, 0);
      check("s7_rst_mem_req", mem_req, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      mem_ready = 1'b0;
      base = cyc;
      #1;
      check("s7_instret", instret, 0);
      check("s7_fetch", {mem_req, mem_addr_sel, halted}, 3'b100);

      // unknown opcode 0x7F
      do_reset;
      instr = 32'h0000_007F;
      mem_ready = 1'b1;
`ifdef MC_ILLEGAL_TRAP_EN
      #1;
      check("s8_illegal_reset", illegal, 0);
      goto(3);
      mem_ready = 1'b0;
      #1;
      check("s8_illegal", illegal, 1);
      check("s8_halted", halted, 1);
      check("s8_instret", instret, 0);
`else
      expect_ev(3, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1);
      goto(4);
      mem_ready = 1'b0;
      #1;
      check("s8_instret", instret, 1);
      check("s8_halted", halted, 0);
`endif

      do_reset;
      repeat (3) @(posedge clk);
      check("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle RV32I control FSM; sequences the shared datapath: IR, register file, immediate generator, single ALU, PC, unified memory port.
- Decodes opcode from the latched IR, drives datapath mux selects and write strobes, handshakes with memory, counts retired instructions.
- Sits between the IR/immediate-extend logic and the datapath top.

Parameters:
- MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready before bus error.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- instr  in  32  current IR contents
- branch_cond  in  1  comparator result for the current branch funct3
- mem_ready  in  1  memory accepts/completes the request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  1 = store
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_we  out  1  latch fetched word into IR
- ab_we  out  1  latch rs1/rs2 operands and immediate
- tgt_we  out  1  latch ALU result into branch-target register
- alu_a_sel  out  2  0 = rs1, 1 = PC, 2 = zero
- alu_b_sel  out  2  0 = rs2, 1 = imm, 2 = const 4
- rf_we  out  1  register-file write
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4
- pc_we  out  1  PC write
- pc_src  out  2  0 = PC+4, 1 = target register, 2 = ALU result with bit0 cleared
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  CNT_W  retired-instruction count
- bus_err  out  1  sticky; memory timeout occurred
- halted  out  1  FSM in HALT

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Outputs are combinational from state and opcode (instr[6:0]); instret and bus_err are registered.
- Reset (rst sampled high): state = FETCH, instret = 0, bus_err = 0, timeout counter = 0. While rst is high every strobe is forced 0, including mem_req. The first mem_req is asserted in the first cycle after rst deasserts.
- Reset mid-operation: rst has priority in any state; no pc_we or rf_we is issued in that cycle.
- FETCH:
  - mem_req = 1, mem_addr_sel = 0.
  - On mem_ready: ir_we = 1, go to DECODE.
  - mem_req stays high until mem_ready is seen; it is never withdrawn.
- DECODE: ab_we = 1, tgt_we = 1, ALU = PC + imm; go to EXEC.
- EXEC, by opcode:
  - OP/OP-IMM: alu_b_sel = 0 or 1, go to WB.
  - LOAD/STORE: ALU = rs1 + imm, go to MEM.
  - BRANCH: ALU compares rs1 vs rs2; pc_we = 1, pc_src = branch_cond ? 1 : 0; retire; go to FETCH.
  - JAL: pc_we = 1, pc_src = 1, go to WB.
  - JALR: ALU = rs1 + imm, pc_we = 1, pc_src = 2, go to WB.
  - LUI: ALU = 0 + imm. AUIPC: ALU = PC + imm. Both go to WB.
  - SYSTEM (CSR): treated as a no-op; pc_we = 1, pc_src = 0, retire, go to FETCH.
- MEM:
  - mem_req = 1, mem_addr_sel = 1, mem_we = (opcode == STORE).
  - On mem_ready: a load goes to WB; a store issues pc_we (src 0) plus retire and goes to FETCH.
- WB:
  - rf_we = 1; wb_sel = 1 for load, 2 for JAL/JALR, else 0.
  - pc_we = 1, pc_src = 0 except JAL/JALR, which updated PC in EXEC and issue no pc_we here.
  - retire = 1, go to FETCH.
- Timeout:
  - Counter increments each cycle mem_req = 1 and mem_ready = 0; it clears on mem_ready or on leaving the state.
  - On reaching MEM_TIMEOUT: bus_err = 1, go to HALT.
- HALT: all strobes 0; left only by rst.
- Counter: instret increments by 1 on each retire and wraps modulo 2^CNT_W.
- Unknown opcode without the optional feature: treated as a no-op (retire, PC+4).

Optional Feature:
- Macro MC_ILLEGAL_TRAP_EN.
- Defined: unknown opcode in DECODE sets a sticky output illegal (1 bit, reset 0), no retire, go to HALT.
- Undefined: no illegal port; unknown opcode is a no-op as above.

Decomposition:
- Package mc_pkg holds:
  - opcode localparams (ArithmeticR/I, MemoryLoad/Store, Conditionjump, JumpandlinkR/I, Adduppertopc, Loadupperimm, ControlStatus);
  - state enum encoding;
  - pc_src / wb_sel / alu select encodings.
- One sub-module, mc_mem_timer: timeout counter plus bus_err flag.

Test Plan:
- Each scenario begins after rst is deasserted.
- addi x1,x0,5 (0x00500093), mem_ready = 1 immediately -> states F, D, E, W; rf_we and retire in cycle 4, wb_sel = 0, pc_src = 0; instret = 1.
- sw x2,0(x1) (0x0020A023), mem_ready delayed 3 cycles in MEM -> mem_we = 1 held 4 cycles; pc_we with retire on the accept cycle; rf_we never asserted.
- beq (0x00000463) with branch_cond = 1, then again with 0 -> pc_src = 1, then 0, in the EXEC cycle; each retires in 3 cycles.
- mem_ready held 0 in FETCH -> bus_err = 1 and halted = 1 after exactly 16 cycles of mem_req; rst then returns to FETCH with bus_err = 0.
- rst pulsed during MEM of lw (0x0000A083) -> no rf_we or pc_we; state = FETCH and instret = 0 afterwards.
- With MC_ILLEGAL_TRAP_EN: word 0x0000007F -> illegal = 1, halted = 1, instret unchanged. Without the macro -> retire, pc_src = 0.
